// File: rtl/pio_out_pkg.sv
// Purpose: shared register map and timer state encoding for the pulse-capable PIO output block.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pio_out_pkg;

  // Avalon-MM word addresses; 5..7 are reserved and decode to nothing.
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_PULSE  = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  typedef enum logic {
    TMR_IDLE   = 1'b0,
    TMR_ACTIVE = 1'b1
  } tmr_state_t;

endpackage

// File: rtl/pio_pulse_timer.sv
// Purpose: one-shot down-counter that times the pulsed bits of pio_out_pulse.
// Latency: expire asserts combinationally in the PULSE_CYCLES-th cycle after the load edge.
// Backpressure: none; load always wins (retrigger reloads), cancel forces idle.
//
// Ports: clk, reset (sync, active-high), load (reload + go active),
//        cancel (abort, go idle), expire (this edge ends the pulse), busy (active).
module pio_pulse_timer
  import pio_out_pkg::*;
#(
  parameter int PULSE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic cancel,
  output logic expire,
  output logic busy
);

  localparam int            CW     = $clog2(PULSE_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  tmr_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= TMR_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Loaded with PULSE_CYCLES-1 at the write edge, the counter reaches zero
  // PULSE_CYCLES-1 edges later and the following edge is the expiry edge,
  // so the pulsed bits are high for exactly PULSE_CYCLES cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    expire    = 1'b0;
    if (load) begin
      // A same-cycle reload suppresses the expiry entirely.
      state_nxt = TMR_ACTIVE;
      cnt_nxt   = RELOAD;
    end else if (cancel) begin
      state_nxt = TMR_IDLE;
      cnt_nxt   = '0;
    end else if (state == TMR_ACTIVE) begin
      if (cnt == '0) begin
        expire    = 1'b1;
        state_nxt = TMR_IDLE;
      end else begin
        cnt_nxt = cnt - ONE;
      end
    end
  end

  assign busy = (state == TMR_ACTIVE);

endmodule

// File: rtl/pio_out_pulse.sv
// Purpose: Avalon-MM PIO output register with DATA/SET/CLEAR and optional self-clearing PULSE.
// Latency: writes reach out_port on the accepting edge; reads are combinational (latency 0).
// Backpressure: none; every chipselect&~write_n cycle is accepted.
//
// Ports: clk, reset (sync, active-high), address[2:0], chipselect, write_n,
//        writedata[31:0], readdata[31:0] (zero-extended), out_port[WIDTH-1:0] (registered).
// Build option: define PIO_OUT_PULSE_EN to include the PULSE register and STATUS busy bit;
//               without it PULSE writes are dropped and STATUS reads zero.
module pio_out_pulse
  import pio_out_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int               PULSE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data, data_nxt;
  logic             wr_en, wr_data, wr_set, wr_clr;
  logic             busy;

  assign wd      = writedata[WIDTH-1:0];
  assign wr_en   = chipselect & ~write_n;
  assign wr_data = wr_en && (address == ADDR_DATA);
  assign wr_set  = wr_en && (address == ADDR_SET);
  assign wr_clr  = wr_en && (address == ADDR_CLEAR);

  // Bits of writedata above WIDTH are architecturally ignored.
  logic unused_wd;
  assign unused_wd = &{1'b0, writedata};

`ifdef PIO_OUT_PULSE_EN
  logic [WIDTH-1:0] mask, mask_nxt;
  logic             wr_pulse, expire;

  // An all-zero PULSE write must not touch the timer, so it is filtered here.
  assign wr_pulse = wr_en && (address == ADDR_PULSE) && (|wd);

  pio_pulse_timer #(
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (wr_pulse),
    .cancel (wr_data),
    .expire (expire),
    .busy   (busy)
  );
`else
  assign busy = 1'b0;
`endif

  // Expiry is applied first and the same-cycle write on top of it; a PULSE
  // write never sees an expiry because the timer suppresses it on reload.
  always_comb begin
    data_nxt = data;
`ifdef PIO_OUT_PULSE_EN
    mask_nxt = mask;
    if (expire) begin
      data_nxt = data & ~mask;
      mask_nxt = '0;
    end
`endif
    if (wr_data) begin
      data_nxt = wd;
`ifdef PIO_OUT_PULSE_EN
      mask_nxt = '0;
`endif
    end else if (wr_set) begin
      data_nxt = data_nxt | wd;
    end else if (wr_clr) begin
      data_nxt = data_nxt & ~wd;
`ifdef PIO_OUT_PULSE_EN
      // Cleared bits stop being owned by the pulse.
      mask_nxt = mask_nxt & ~wd;
`endif
    end
`ifdef PIO_OUT_PULSE_EN
    else if (wr_pulse) begin
      data_nxt = data | wd;
      mask_nxt = mask | wd;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data <= RESET_VALUE;
`ifdef PIO_OUT_PULSE_EN
      mask <= '0;
`endif
    end else begin
      data <= data_nxt;
`ifdef PIO_OUT_PULSE_EN
      mask <= mask_nxt;
`endif
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0] = data;
      ADDR_STATUS: readdata[0]         = busy;
      default:     ;
    endcase
  end

  assign out_port = data;

endmodule

// File: tb/tb_pio_out_pulse.sv
// Purpose: self-checking bench for pio_out_pulse (WIDTH=8, RESET_VALUE=8'hA5, PULSE_CYCLES=4).
// Latency: checks out_port on the write edge and readdata combinationally.
// Backpressure: n/a.
module tb_pio_out_pulse;

  localparam int         P  = 4;
  localparam logic [7:0] RV = 8'hA5;
`ifdef PIO_OUT_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int total = 0;
  int bad   = 0;

  pio_out_pulse #(
    .WIDTH        (8),
    .RESET_VALUE  (RV),
    .PULSE_CYCLES (P)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: register contents plus the absolute cycle at which the pending
  // pulse ends (-1 when no pulse is pending).
  int         cyc      = 0;
  bit         model_on = 1'b0;
  logic [7:0] m_data;
  logic [7:0] m_mask;
  int         m_end;

  always @(posedge clk) begin
    logic [7:0] w;
    logic       we;
    cyc++;
    if (reset) begin
      m_data   = RV;
      m_mask   = '0;
      m_end    = -1;
      model_on = 1'b1;
    end else if (model_on) begin
      w  = writedata[7:0];
      we = chipselect && !write_n;
      if (PULSE_EN && m_end == cyc && !(we && address == 3'd3 && w != 8'h00)) begin
        m_data = m_data & ~m_mask;
        m_mask = '0;
        m_end  = -1;
      end
      if (we) begin
        case (address)
          3'd0: begin m_data = w; m_mask = '0; m_end = -1; end
          3'd1: m_data = m_data | w;
          3'd2: begin m_data = m_data & ~w; m_mask = m_mask & ~w; end
          3'd3: if (PULSE_EN && w != 8'h00) begin
                  m_data = m_data | w;
                  m_mask = m_mask | w;
                  m_end  = cyc + P;
                end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_rd;
    if (model_on) begin
      exp_rd = '0;
      if (address == 3'd0) exp_rd[7:0] = m_data;
      else if (address == 3'd4) exp_rd[0] = PULSE_EN && (m_end != -1);
      chk("model_out_port", {24'h0, out_port}, {24'h0, m_data});
      chk("model_readdata", readdata, exp_rd);
    end
  end

  // All driving happens 2 time units after a rising edge.
  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    address    = a;
    writedata  = {24'hDEAD00, d};
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #2;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(nm, readdata, exp);
  endtask

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    idle(2);
    reset = 1'b0;

    chk("reset_out", {24'h0, out_port}, 32'h0000_00A5);
    rd_chk("reset_status", 3'd4, 32'h0);
    rd_chk("reset_data", 3'd0, 32'h0000_00A5);

    bus_wr(3'd0, 8'h0F); chk("data_wr", {24'h0, out_port}, 32'h0F);
    bus_wr(3'd1, 8'hF0); chk("set_wr", {24'h0, out_port}, 32'hFF);
    bus_wr(3'd2, 8'h03); chk("clear_wr", {24'h0, out_port}, 32'hFC);
    rd_chk("data_rd", 3'd0, 32'hFC);

    bus_wr(3'd5, 8'hFF);
    bus_wr(3'd4, 8'h00);
    chk("reserved_wr", {24'h0, out_port}, 32'hFC);

`ifdef PIO_OUT_PULSE_EN
    // Single pulse: high for exactly P cycles.
    bus_wr(3'd0, 8'h00);
    bus_wr(3'd3, 8'h01);
    chk("pulse_start", {24'h0, out_port}, 32'h01);
    rd_chk("pulse_busy", 3'd4, 32'h1);
    for (int i = 1; i < P; i++) begin
      idle(1);
      chk("pulse_hold", {24'h0, out_port}, 32'h01);
      rd_chk("pulse_hold_busy", 3'd4, 32'h1);
    end
    idle(1);
    chk("pulse_end", {24'h0, out_port}, 32'h00);
    rd_chk("pulse_end_busy", 3'd4, 32'h0);

    // Zero-mask pulse does nothing.
    bus_wr(3'd3, 8'h00);
    rd_chk("pulse_zero_busy", 3'd4, 32'h0);

    // Retrigger with a second bit two cycles later.
    bus_wr(3'd3, 8'h01);
    idle(1);
    bus_wr(3'd3, 8'h02);
    chk("retrig_both", {24'h0, out_port}, 32'h03);
    idle(P - 1);
    chk("retrig_hold", {24'h0, out_port}, 32'h03);
    idle(1);
    chk("retrig_end", {24'h0, out_port}, 32'h00);

    // CLEAR in the expiry cycle.
    bus_wr(3'd3, 8'h03);
    idle(P - 1);
    chk("exp_clr_pre", {24'h0, out_port}, 32'h03);
    bus_wr(3'd2, 8'h01);
    chk("exp_clr_out", {24'h0, out_port}, 32'h00);
    rd_chk("exp_clr_busy", 3'd4, 32'h0);

    // SET in the expiry cycle re-raises the bit after the clear.
    bus_wr(3'd3, 8'h01);
    idle(P - 1);
    bus_wr(3'd1, 8'h01);
    chk("exp_set_out", {24'h0, out_port}, 32'h01);
    rd_chk("exp_set_busy", 3'd4, 32'h0);

    // PULSE in the expiry cycle overrides the expiry.
    bus_wr(3'd0, 8'h00);
    bus_wr(3'd3, 8'h01);
    idle(P - 1);
    bus_wr(3'd3, 8'h02);
    chk("exp_pulse_out", {24'h0, out_port}, 32'h03);
    idle(P - 1);
    chk("exp_pulse_hold", {24'h0, out_port}, 32'h03);
    idle(1);
    chk("exp_pulse_end", {24'h0, out_port}, 32'h00);

    // Reset in the middle of a pulse.
    bus_wr(3'd3, 8'h0C);
    idle(1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("midrst_out", {24'h0, out_port}, 32'hA5);
    rd_chk("midrst_busy", 3'd4, 32'h0);
    idle(P + 1);
    chk("midrst_after", {24'h0, out_port}, 32'hA5);
`else
    bus_wr(3'd3, 8'hFF);
    chk("nopulse_out", {24'h0, out_port}, 32'hFC);
    rd_chk("nopulse_status", 3'd4, 32'h0);
    idle(P + 1);
    chk("nopulse_after", {24'h0, out_port}, 32'hFC);
`endif

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
